// File: rtl/idct_2d.sv
`default_nettype none
// ============================================================================
//  Module      : idct_2d
//  Description : Inverse 8x8 2D DCT. A row pass followed by a column pass,
//                one output element per clock on a shared 8-multiplier
//                datapath. Produces a signed 9-bit pixel block with a
//                one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module idct_2d #(
    parameter int COEF_W   = 16,
    parameter int COS_FRAC = 14,
    parameter int IW       = COEF_W + 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_block,
    input  logic [7:0][7:0][COEF_W-1:0]    coef_block,
    output logic [7:0][7:0][8:0]           pixel_block_out,
    output logic                           block_done,
    output logic                           busy
);

    // Accumulator wide enough for either pass (column pass operands are IW bits)
    localparam int SUM_W = IW + COS_FRAC + 5;
    localparam int CW    = COS_FRAC + 2;

    localparam logic signed [SUM_W-1:0] c_HALF   = SUM_W'(1 << (COS_FRAC - 1));
    localparam logic signed [SUM_W-1:0] c_IW_MAX = SUM_W'((1 << (IW - 1)) - 1);
    localparam logic signed [SUM_W-1:0] c_IW_MIN = SUM_W'(-(1 << (IW - 1)));
    localparam logic signed [SUM_W-1:0] c_P_MAX  = SUM_W'(255);
    localparam logic signed [SUM_W-1:0] c_P_MIN  = SUM_W'(-256);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROW  = 2'd1,
        S_COL  = 2'd2
    } state_t;

    state_t                        r_state;
    logic [5:0]                    r_idx;
    logic [7:0][7:0][COEF_W-1:0]   r_coef;
    logic [7:0][7:0][IW-1:0]       r_t;
    logic [7:0][7:0][8:0]          r_pix;
    logic [7:0][7:0][8:0]          r_pix_out;
    logic                          r_done;
    logic                          r_busy;

    logic [2:0]                    w_y;
    logic [2:0]                    w_x;
    logic signed [IW-1:0]          w_op;
    logic signed [CW-1:0]          w_cs;
    logic signed [SUM_W-1:0]       w_sum;
    logic signed [SUM_W-1:0]       w_shr;
    logic signed [IW-1:0]          w_t_val;
    logic signed [8:0]             w_p_val;
    logic [7:0][7:0][8:0]          w_pix_final;

    // Cosine basis C[u][x]; entries are scaled for 14 fractional bits.
    // The angle index (2x+1)u mod 32 is folded into the first quadrant.
    function automatic logic signed [CW-1:0] f_cos(input logic [2:0] u, input logic [2:0] x);
        logic [6:0]           prod;
        logic [4:0]           m;
        logic                 neg;
        logic signed [CW-1:0] mag;
        prod = 7'(u) * 7'({x, 1'b1});
        m    = prod[4:0];
        neg  = 1'b0;
        if (m > 5'd16) m = 5'd0 - m;
        if (m > 5'd8) begin
            m   = 5'd16 - m;
            neg = 1'b1;
        end
        case (m)
            5'd1:    mag = CW'(8035);
            5'd2:    mag = CW'(7568);
            5'd3:    mag = CW'(6811);
            5'd4:    mag = CW'(5793);
            5'd5:    mag = CW'(4551);
            5'd6:    mag = CW'(3135);
            5'd7:    mag = CW'(1598);
            5'd8:    mag = CW'(0);
            default: mag = CW'(8192);
        endcase
        if (u == 3'd0) begin
            f_cos = CW'(5793);
        end else begin
            f_cos = neg ? -mag : mag;
        end
    endfunction

    // One 8-term dot product per cycle, then rounding shift and saturation
    always_comb begin
        w_y   = r_idx[5:3];
        w_x   = r_idx[2:0];
        w_op  = '0;
        w_cs  = '0;
        w_sum = '0;
        for (int k = 0; k < 8; k++) begin
            if (r_state == S_COL) begin
                w_op = r_t[k][w_x];
                w_cs = f_cos(3'(k), w_y);
            end else begin
                w_op = IW'($signed(r_coef[w_y][k]));
                w_cs = f_cos(3'(k), w_x);
            end
            w_sum = w_sum + SUM_W'(w_op) * SUM_W'(w_cs);
        end
        w_shr = (w_sum + c_HALF) >>> COS_FRAC;

        if (w_shr > c_IW_MAX)      w_t_val = c_IW_MAX[IW-1:0];
        else if (w_shr < c_IW_MIN) w_t_val = c_IW_MIN[IW-1:0];
        else                       w_t_val = w_shr[IW-1:0];

        if (w_shr > c_P_MAX)       w_p_val = c_P_MAX[8:0];
        else if (w_shr < c_P_MIN)  w_p_val = c_P_MIN[8:0];
        else                       w_p_val = w_shr[8:0];

        // Final block includes the element being computed this cycle
        w_pix_final           = r_pix;
        w_pix_final[w_y][w_x] = w_p_val;
    end

    // Control FSM, buffers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_coef    <= '0;
            r_t       <= '0;
            r_pix     <= '0;
            r_pix_out <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Busy drops in the cycle after done unless a new block starts
                    r_busy <= start_block;
                    if (start_block) begin
                        r_coef  <= coef_block;
                        r_idx   <= '0;
                        r_state <= S_ROW;
                    end
                end
                S_ROW: begin
                    r_t[w_y][w_x] <= w_t_val;
                    r_idx         <= r_idx + 6'd1;
                    if (r_idx == 6'd63) r_state <= S_COL;
                end
                S_COL: begin
                    r_pix[w_y][w_x] <= w_p_val;
                    r_idx           <= r_idx + 6'd1;
                    if (r_idx == 6'd63) begin
                        r_pix_out <= w_pix_final;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pixel_block_out = r_pix_out;
    assign block_done      = r_done;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_idct_2d.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idct_2d
//  Description : Directed self-checking bench for idct_2d with hand-computed
//                expected pixel blocks, latency, busy and done behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idct_2d;

    logic                      clk;
    logic                      rst_n;
    logic                      start_block;
    logic [7:0][7:0][15:0]     coef_block;
    logic [7:0][7:0][8:0]      pixel_block_out;
    logic                      block_done;
    logic                      busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done_seen = 0;

    idct_2d #(.COEF_W(16), .COS_FRAC(14), .IW(19)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_block     (start_block),
        .coef_block      (coef_block),
        .pixel_block_out (pixel_block_out),
        .block_done      (block_done),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse so unexpected extra pulses are visible
    always @(posedge clk) if (block_done === 1'b1) n_done_seen <= n_done_seen + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0][7:0][8:0] fill(input int v);
        logic [7:0][7:0][8:0] r;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                r[y][x] = v[8:0];
        return r;
    endfunction

    function automatic logic [7:0][7:0][15:0] one_coef(input int v, input int u, input int val);
        logic [7:0][7:0][15:0] r;
        r       = '0;
        r[v][u] = val[15:0];
        return r;
    endfunction

    function automatic int mis_count(input logic [7:0][7:0][8:0] e);
        int mis = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (pixel_block_out[y][x] !== e[y][x]) mis++;
        return mis;
    endfunction

    // Start a block, wait for done, check latency, busy, pixels and pulse width
    task automatic run_block(input string tag, input logic [7:0][7:0][15:0] c,
                             input logic [7:0][7:0][8:0] e);
        int cyc;
        int busy_low;
        coef_block  = c;
        start_block = 1'b1;
        @(negedge clk);
        start_block = 1'b0;
        chk({tag, "_busy_e0"}, int'(busy), 1);
        cyc = 0;
        busy_low = 0;
        while (block_done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (busy !== 1'b1) busy_low++;
        end
        chk({tag, "_latency"}, cyc, 128);
        chk({tag, "_busy_low"}, busy_low, 0);
        chk({tag, "_pix_mis"}, mis_count(e), 0);
        @(negedge clk);
        chk({tag, "_done_width"}, int'(block_done), 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    logic [7:0][7:0][8:0] e3;
    int row3 [8] = '{17, 15, 10, 4, -4, -10, -15, -17};
    int cyc;
    int d0;

    initial begin
        rst_n       = 1'b0;
        start_block = 1'b0;
        coef_block  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(block_done), 0);
        chk("rst_pix", mis_count(fill(0)), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero block
        run_block("zero", '0, fill(0));

        // DC only: t[0][x]=23, every pixel 8
        run_block("dc64", one_coef(0, 0, 64), fill(8));
        chk("dc64_p77", int'($signed(pixel_block_out[7][7])), 8);

        // First horizontal frequency
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                e3[y][x] = row3[x][8:0];
        run_block("ac01", one_coef(0, 1, 100), e3);
        chk("ac01_p00", int'($signed(pixel_block_out[0][0])), 17);
        chk("ac01_p52", int'($signed(pixel_block_out[5][2])), 10);
        chk("ac01_p77", int'($signed(pixel_block_out[7][7])), -17);

        // Saturation at both ends
        run_block("satp", one_coef(0, 0, 4000), fill(255));
        run_block("satn", one_coef(0, 0, -4000), fill(-256));
        chk("satn_p34", int'($signed(pixel_block_out[3][4])), -256);

        // Starts while busy are ignored; start held through done is accepted
        d0 = n_done_seen;
        coef_block  = one_coef(0, 0, 64);
        start_block = 1'b1;
        @(negedge clk);
        start_block = 1'b0;
        repeat (9) @(negedge clk);
        start_block = 1'b1;
        @(negedge clk);
        start_block = 1'b0;
        repeat (89) @(negedge clk);
        start_block = 1'b1;
        @(negedge clk);
        start_block = 1'b0;
        repeat (19) @(negedge clk);
        start_block = 1'b1;
        cyc = 119;
        while (block_done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_latency", cyc, 128);
        chk("ign_pix", mis_count(fill(8)), 0);
        @(negedge clk);
        start_block = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_done_low", int'(block_done), 0);
        cyc = 1;
        while (block_done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_period", cyc, 129);
        chk("b2b_pix", mis_count(fill(8)), 0);
        @(negedge clk);
        chk("b2b_busy_after", int'(busy), 0);
        chk("b2b_done_count", n_done_seen - d0, 2);

        // Reset mid-block aborts without a done pulse
        d0 = n_done_seen;
        coef_block  = one_coef(0, 0, 4000);
        start_block = 1'b1;
        @(negedge clk);
        start_block = 1'b0;
        repeat (69) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(block_done), 0);
        chk("abort_pix", mis_count(fill(0)), 0);
        repeat (200) @(negedge clk);
        chk("abort_no_done", n_done_seen - d0, 0);
        chk("abort_idle_busy", int'(busy), 0);
        run_block("post", one_coef(0, 0, 64), fill(8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
